instr_decode_stage: RTL

//  Pipelined decode stage: consumes raw 32-bit instruction words from fetch and emits decoded

---
 rtl/instr_decode_stage.sv | 196 +++++++++++++++++++
 1 files changed

// File: rtl/instr_decode_stage.sv
// Decode stage between fetch and execute: decodes raw instruction words into fields and
// control flags, buffered by an output register plus a skid register so in_ready is registered.
module instr_decode_stage #(
   parameter int PC_W = 32
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            flush,
   input  logic            in_valid,
   output logic            in_ready,
   input  logic [31:0]     in_instr,
   input  logic [PC_W-1:0] in_pc,
   output logic            out_valid,
   input  logic            out_ready,
   output logic [PC_W-1:0] out_pc,
   output logic [6:0]      out_op,
   output logic [2:0]      out_funct3,
   output logic [6:0]      out_funct7,
   output logic [4:0]      out_rd,
   output logic [4:0]      out_cond,
   output logic [4:0]      out_rs1,
   output logic [4:0]      out_rs2,
   output logic [31:0]     out_imm,
   output logic            out_uses_rs1,
   output logic            out_uses_rs2,
   output logic            out_writes_rd,
   output logic            out_illegal
);

   typedef enum logic [6:0] {
      OP_NOP    = 7'h00,
      OP_LD     = 7'h03,
      OP_ARITHI = 7'h13,
      OP_LDUIPC = 7'h17,
      OP_ST     = 7'h23,
      OP_ARITH  = 7'h33,
      OP_LDUI   = 7'h37,
      OP_BR     = 7'h63,
      OP_JALR   = 7'h67,
      OP_BRR    = 7'h6B,
      OP_JAL    = 7'h6F
   } op_t;

   typedef struct packed {
      logic [6:0] funct7;
      logic [4:0] rs2;
      logic [4:0] rs1;
      logic [2:0] funct3;
      logic [4:0] rd;
      logic [6:0] op;
   } enc_t;

   typedef struct packed {
      logic [PC_W-1:0] pc;
      logic [6:0]      op;
      logic [2:0]      funct3;
      logic [6:0]      funct7;
      logic [4:0]      rd;
      logic [4:0]      cond;
      logic [4:0]      rs1;
      logic [4:0]      rs2;
      logic [31:0]     imm;
      logic            uses_rs1;
      logic            uses_rs2;
      logic            writes_rd;
      logic            illegal;
   } beat_t;

   enc_t  enc_s;
   beat_t dec_s;
   beat_t out_r;
   beat_t skid_r;
   logic  out_valid_r;
   logic  skid_valid_r;
   logic  accept_s;

   assign enc_s    = in_instr;
   assign accept_s = in_valid && !skid_valid_r && !flush;

   // Combinational decode of the word currently offered by fetch.
   always_comb begin
      dec_s    = '0;
      dec_s.pc = in_pc;
      dec_s.op = enc_s.op;
      case (enc_s.op)
         OP_ARITH: begin
            dec_s.funct3    = enc_s.funct3;
            dec_s.funct7    = enc_s.funct7;
            dec_s.uses_rs1  = 1'b1;
            dec_s.uses_rs2  = 1'b1;
            dec_s.writes_rd = 1'b1;
         end
         OP_ARITHI, OP_JALR: begin
            dec_s.funct3    = enc_s.funct3;
            dec_s.imm       = {{20{in_instr[31]}}, in_instr[31:20]};
            dec_s.uses_rs1  = 1'b1;
            dec_s.writes_rd = 1'b1;
         end
         OP_LD: begin
            dec_s.funct3    = enc_s.funct3;
            dec_s.imm       = {{20{in_instr[31]}}, in_instr[31:20]};
            dec_s.uses_rs1  = 1'b1;
            dec_s.writes_rd = 1'b1;
            dec_s.illegal   = (enc_s.funct3 == 3'b011) || (enc_s.funct3 == 3'b110) ||
                              (enc_s.funct3 == 3'b111);
         end
         OP_ST: begin
            dec_s.funct3    = enc_s.funct3;
            dec_s.imm       = {{20{in_instr[31]}}, in_instr[31:25], in_instr[11:7]};
            dec_s.uses_rs1  = 1'b1;
            dec_s.uses_rs2  = 1'b1;
            dec_s.illegal   = (enc_s.funct3 > 3'b010);
         end
         OP_LDUI, OP_LDUIPC: begin
            dec_s.imm       = {in_instr[31:12], 12'h000};
            dec_s.writes_rd = 1'b1;
         end
         OP_JAL: begin
            dec_s.imm       = {{10{in_instr[31]}}, in_instr[31:12], 2'b00};
            dec_s.writes_rd = 1'b1;
         end
         OP_BR: begin
            dec_s.imm       = {{10{in_instr[31]}}, in_instr[31:12], 2'b00};
            dec_s.cond      = enc_s.rd;
         end
         OP_BRR: begin
            dec_s.funct3    = enc_s.funct3;
            dec_s.imm       = {{20{in_instr[31]}}, in_instr[31:20]};
            dec_s.uses_rs1  = 1'b1;
            dec_s.cond      = enc_s.rd;
         end
         OP_NOP: begin
            dec_s.illegal   = 1'b0;
         end
         default: begin
            dec_s.illegal   = 1'b1;
         end
      endcase
      // An illegal word keeps only its pc and opcode so execute can trap on it.
      if (dec_s.illegal) begin
         dec_s         = '0;
         dec_s.pc      = in_pc;
         dec_s.op      = enc_s.op;
         dec_s.illegal = 1'b1;
      end else begin
         dec_s.writes_rd = dec_s.writes_rd && (enc_s.rd != 5'd0);
      end
      dec_s.rd  = dec_s.writes_rd ? enc_s.rd  : 5'd0;
      dec_s.rs1 = dec_s.uses_rs1  ? enc_s.rs1 : 5'd0;
      dec_s.rs2 = dec_s.uses_rs2  ? enc_s.rs2 : 5'd0;
   end

   // Output register and skid register; skid drains first to keep strict FIFO order.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         out_valid_r  <= 1'b0;
         skid_valid_r <= 1'b0;
         out_r        <= '0;
         skid_r       <= '0;
      end else if (flush) begin
         out_valid_r  <= 1'b0;
         skid_valid_r <= 1'b0;
      end else if (!out_valid_r || out_ready) begin
         if (skid_valid_r) begin
            out_r        <= skid_r;
            out_valid_r  <= 1'b1;
            skid_valid_r <= 1'b0;
         end else if (accept_s) begin
            out_r        <= dec_s;
            out_valid_r  <= 1'b1;
         end else begin
            out_valid_r  <= 1'b0;
         end
      end else if (accept_s) begin
         skid_r       <= dec_s;
         skid_valid_r <= 1'b1;
      end
   end

   assign in_ready      = !skid_valid_r;
   assign out_valid     = out_valid_r;
   assign out_pc        = out_r.pc;
   assign out_op        = out_r.op;
   assign out_funct3    = out_r.funct3;
   assign out_funct7    = out_r.funct7;
   assign out_rd        = out_r.rd;
   assign out_cond      = out_r.cond;
   assign out_rs1       = out_r.rs1;
   assign out_rs2       = out_r.rs2;
   assign out_imm       = out_r.imm;
   assign out_uses_rs1  = out_r.uses_rs1;
   assign out_uses_rs2  = out_r.uses_rs2;
   assign out_writes_rd = out_r.writes_rd;
   assign out_illegal   = out_r.illegal;

endmodule
